// File: rtl/modulo_somador_multiplicador_if.sv
// Request/response bundle for one per-element arithmetic engine.
// The requester drives start/op/a/b; the engine returns a registered, saturated result.
interface modulo_somador_multiplicador_if #(
  parameter int WIDTH = 8
);
  logic                    start;
  logic [1:0]              op;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic signed [WIDTH:0]   resultado;
  logic                    overflow;
  logic                    busy;
  logic                    done;

  modport master (
    output start, op, a, b,
    input  resultado, overflow, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output resultado, overflow, busy, done
  );
endinterface

// File: rtl/modulo_somador_multiplicador.sv
// Signed add/sub (single cycle) and iterative shift-add multiply with the result
// saturated to WIDTH+1 bits; one instance per matrix element.
module modulo_somador_multiplicador #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  modulo_somador_multiplicador_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic signed [2*WIDTH:0] SAT_MAX = (2*WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic signed [2*WIDTH:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MUL, DONE_OUT} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_RSV = 2'b11} op_t;

  state_t                   state, next_state;
  logic [CW-1:0]            count;
  logic [2*WIDTH-1:0]       acc;
  logic [2*WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]         mplier;
  logic                     neg;
  logic [WIDTH:0]           res_q;
  logic                     ovf_q;
  logic                     done_q;

  logic                     load;
  logic                     mul_start;
  logic [WIDTH:0]           res_next;
  logic                     ovf_next;
  logic [WIDTH:0]           sum_ab;
  logic [WIDTH:0]           diff_ab;
  logic [WIDTH-1:0]         a_mag;
  logic [WIDTH-1:0]         b_mag;
  logic signed [2*WIDTH:0]  prod;

  assign sum_ab  = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
  assign diff_ab = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};
  // Magnitude of the most negative value wraps to 2**(WIDTH-1), which is correct unsigned.
  assign a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign prod    = neg ? -$signed({1'b0, acc}) : $signed({1'b0, acc});

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    mul_start  = 1'b0;
    res_next   = '0;
    ovf_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          case (op_t'(bus.op))
            OP_ADD: begin load = 1'b1; res_next = sum_ab;  end
            OP_SUB: begin load = 1'b1; res_next = diff_ab; end
            OP_MUL: begin mul_start = 1'b1; next_state = MUL; end
            default: load = 1'b1;
          endcase
        end
      end
      MUL: begin
        if (count == CW'(WIDTH - 1)) next_state = DONE_OUT;
      end
      DONE_OUT: begin
        load       = 1'b1;
        next_state = IDLE;
        if (prod > SAT_MAX) begin
          res_next = SAT_MAX[WIDTH:0];
          ovf_next = 1'b1;
        end else if (prod < SAT_MIN) begin
          res_next = SAT_MIN[WIDTH:0];
          ovf_next = 1'b1;
        end else begin
          res_next = prod[WIDTH:0];
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: the datapath registers are plain flops, not a memory, so they are reset with the rest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (mul_start) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        count  <= '0;
      end else if (state == MUL) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
      end
      if (load) begin
        res_q <= res_next;
        ovf_q <= ovf_next;
      end
      done_q <= load;
    end
  end

  assign bus.resultado = res_q;
  assign bus.overflow  = ovf_q;
  assign bus.done      = done_q;
  // Busy covers the final DONE_OUT cycle too, so a start there cannot slip in.
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_modulo_somador_multiplicador.sv
// Directed bench for modulo_somador_multiplicador: add/sub, exact and saturating
// multiply, busy protection, mid-operation reset, reserved op and back-to-back starts.
module tb_modulo_somador_multiplicador;
  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  modulo_somador_multiplicador_if #(.WIDTH(8)) bus ();

  modulo_somador_multiplicador #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive one start pulse; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input int a, input int b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = 8'(a);
    bus.b     = 8'(b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs a multiply and watches up to 12 cycles for done pulses.
  task automatic do_mul(input int a, input int b, output int lat, output logic [8:0] res,
                        output logic ovf, output logic busy1, output int ndone);
    issue(2'b10, a, b);
    busy1 = bus.busy;
    ndone = 0;
    lat   = -1;
    res   = 'x;
    ovf   = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          res = bus.resultado;
          ovf = bus.overflow;
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.resultado, bus.overflow, bus.busy, bus.done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got res=%h ovf=%b busy=%b done=%b, need all 0",
               bus.resultado, bus.overflow, bus.busy, bus.done);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add_sub;
    int          va [4] = '{100, -128, -128, 127};
    int          vb [4] = '{100,  127, -128, 127};
    logic [1:0]  vo [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
    logic [8:0]  ve [4] = '{9'h0C8, 9'h101, 9'h100, 9'h0FE};
    for (int i = 0; i < 4; i++) begin
      issue(vo[i], va[i], vb[i]);
      n_checks++;
      if (bus.done !== 1'b1 || bus.resultado !== ve[i] || bus.overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL addsub[%0d]: got done=%b res=%h ovf=%b, need done=1 res=%h ovf=0",
                 i, bus.done, bus.resultado, bus.overflow, ve[i]);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.resultado !== ve[i]) begin
        n_fail++;
        $display("FAIL addsub_pulse[%0d]: got done=%b res=%h, need done=0 res=%h",
                 i, bus.done, bus.resultado, ve[i]);
      end
    end
  endtask

  task automatic run_mul_table(input string name, input int va [], input int vb [],
                               input int ve [], input logic vovf);
    int lat, ndone;
    logic [8:0] res;
    logic ovf, busy1;
    for (int i = 0; i < va.size(); i++) begin
      do_mul(va[i], vb[i], lat, res, ovf, busy1, ndone);
      n_checks++;
      if (busy1 !== 1'b1 || lat != 9 || ndone != 1) begin
        n_fail++;
        $display("FAIL %s_timing[%0d]: got busy=%b latency=%0d dones=%0d, need busy=1 latency=9 dones=1",
                 name, i, busy1, lat, ndone);
      end
      n_checks++;
      if (res !== 9'(ve[i]) || ovf !== vovf) begin
        n_fail++;
        $display("FAIL %s_value[%0d]: %0d*%0d got res=%h ovf=%b, need res=%h ovf=%b",
                 name, i, va[i], vb[i], res, ovf, 9'(ve[i]), vovf);
      end
    end
  endtask

  task automatic test_mul_exact;
    int va [] = '{12, -1, 15, -16, 0};
    int vb [] = '{-10, -1, 17, 16, -77};
    int ve [] = '{-120, 1, 255, -256, 0};
    run_mul_table("mul_exact", va, vb, ve, 1'b0);
  endtask

  task automatic test_mul_saturation;
    int va [] = '{100, -128, -128, 16};
    int vb [] = '{100, 127, -128, 16};
    int ve [] = '{255, -256, 255, 255};
    run_mul_table("mul_sat", va, vb, ve, 1'b1);
  endtask

  task automatic test_busy_protection;
    int lat = -1;
    int ndone = 0;
    logic [8:0] res = 'x;
    logic busy_mid = 1'b0;
    issue(2'b10, 7, 7);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 2) begin
        busy_mid  = bus.busy;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 8'sd100;
        bus.b     = -8'sd3;
      end
      if (k == 3) bus.start = 1'b0;
      if (k == 5) bus.a = -8'sd9;
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          res = bus.resultado;
        end
      end
    end
    n_checks++;
    if (busy_mid !== 1'b1 || ndone != 1 || lat != 9) begin
      n_fail++;
      $display("FAIL busy_protect_timing: got busy=%b dones=%0d latency=%0d, need busy=1 dones=1 latency=9",
               busy_mid, ndone, lat);
    end
    n_checks++;
    if (res !== 9'd49) begin
      n_fail++;
      $display("FAIL busy_protect_value: got res=%h, need res=031", res);
    end
  endtask

  task automatic test_reset_mid_op;
    int ndone = 0;
    issue(2'b10, 50, 3);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.resultado, bus.overflow, bus.busy, bus.done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_op: got res=%h ovf=%b busy=%b done=%b, need all 0",
               bus.resultado, bus.overflow, bus.busy, bus.done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d cycles with done/busy, need 0", ndone);
    end
    issue(2'b00, 1, 2);
    n_checks++;
    if (bus.done !== 1'b1 || bus.resultado !== 9'd3) begin
      n_fail++;
      $display("FAIL reset_then_add: got done=%b res=%h, need done=1 res=003", bus.done, bus.resultado);
    end
  endtask

  task automatic test_reserved_hold;
    int bad = 0;
    issue(2'b00, 5, 6);
    n_checks++;
    if (bus.resultado !== 9'd11) begin
      n_fail++;
      $display("FAIL reserved_setup: got res=%h, need res=00b", bus.resultado);
    end
    issue(2'b11, 55, 66);
    n_checks++;
    if (bus.done !== 1'b1 || bus.resultado !== 9'd0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved_op: got done=%b res=%h ovf=%b, need done=1 res=000 ovf=0",
               bus.done, bus.resultado, bus.overflow);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.resultado !== 9'd0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_idle: got %0d cycles with done or nonzero result, need 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int         va [4] = '{1, 10, -50, 127};
    int         vb [4] = '{2, -4, -60, -128};
    logic [1:0] vo [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic [8:0] ve [4] = '{9'h003, 9'h00E, 9'h192, 9'h0FF};
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = vo[0]; bus.a = 8'(va[0]); bus.b = 8'(vb[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b1 || bus.resultado !== ve[i] || bus.overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got done=%b res=%h ovf=%b, need done=1 res=%h ovf=0",
                 i, bus.done, bus.resultado, bus.overflow, ve[i]);
      end
      if (i < 3) begin
        bus.op = vo[i+1]; bus.a = 8'(va[i+1]); bus.b = 8'(vb[i+1]);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.resultado !== 9'h0FF) begin
      n_fail++;
      $display("FAIL back_to_back_end: got done=%b res=%h, need done=0 res=0ff", bus.done, bus.resultado);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_add_sub();
    test_mul_exact();
    test_mul_saturation();
    test_busy_protection();
    test_reset_mid_op();
    test_reserved_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
